// File: rtl/karatsuba_18b_uc_pkg.sv
// Shared definitions for the 18x18 Karatsuba multiplier control unit:
// state encoding, datapath select codes and the per-state control word.
package karatsuba_18b_uc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_A = 4'd1,
        ST_LOAD_B = 4'd2,
        ST_WAIT   = 4'd3,
        ST_Z02    = 4'd4,
        ST_Z1     = 4'd5,
        ST_HILO   = 4'd6,
        ST_MERGE  = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    // Adder A operand sources
    localparam logic [1:0] SEL_A_A_HI = 2'd0;
    localparam logic [1:0] SEL_A_B_HI = 2'd1;
    localparam logic [1:0] SEL_A_KARA = 2'd2;
    localparam logic [1:0] SEL_A_REGS = 2'd3;

    // Adder B operand sources
    localparam logic [1:0] SEL_B_A_LO  = 2'd0;
    localparam logic [1:0] SEL_B_B_LO  = 2'd1;
    localparam logic [1:0] SEL_B_REG3  = 2'd2;
    localparam logic [1:0] SEL_B_KARA2 = 2'd3;

    // Which sub-product feeds the A-side kara path
    localparam logic SEL_A1_KARA3 = 1'b0;
    localparam logic SEL_A1_KARA1 = 1'b1;

    // shamt=1 shifts the kara path by 18 and the reg3 path by 9
    localparam logic SHAMT_NONE = 1'b0;
    localparam logic SHAMT_HI   = 1'b1;

    typedef struct packed {
        logic       start1;
        logic       start2;
        logic       start3;
        logic [1:0] sel_alu_a;
        logic [1:0] sel_alu_b;
        logic       sel_alu_a1;
        logic       shamt;
        logic       sub;
        logic       load_reg1;
        logic       load_reg2;
        logic       load_reg3;
        logic       busy;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/karatsuba_18b_uc_if.sv
// Handshake and datapath-control bundle between the multiply sequencer,
// the Karatsuba control unit and the datapath.
interface karatsuba_18b_uc_if;

    // Valid/ready semantics: start is a request sampled only while the unit is
    // idle (busy=0); done or err is a single-cycle response that ends the request.
    logic       start;
    logic       done1;
    logic       done2;
    logic       done3;
    logic       start1;
    logic       start2;
    logic       start3;
    logic [1:0] sel_alu_a;
    logic [1:0] sel_alu_b;
    logic       sel_alu_a1;
    logic       shamt;
    logic       sub;
    logic       load_reg1;
    logic       load_reg2;
    logic       load_reg3;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, done1, done2, done3,
        input  start1, start2, start3, sel_alu_a, sel_alu_b, sel_alu_a1,
               shamt, sub, load_reg1, load_reg2, load_reg3, busy, done, err
    );

    modport slave (
        input  start, done1, done2, done3,
        output start1, start2, start3, sel_alu_a, sel_alu_b, sel_alu_a1,
               shamt, sub, load_reg1, load_reg2, load_reg3, busy, done, err
    );

endinterface

// File: rtl/karatsuba_18b_uc_done_tracker.sv
// Sticky completion flags for the three sub-multipliers plus the WAIT
// timeout counter; both are cleared when a new operation is launched.
module karatsuba_18b_uc_done_tracker #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_capture,
    input  logic       i_count,
    input  logic [2:0] i_done,
    output logic       o_all_done,
    output logic       o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    r_flags;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 3'b000;
            r_count <= '0;
        end else if (i_clear) begin
            r_flags <= 3'b000;
            r_count <= '0;
        end else begin
            if (i_capture) begin
                r_flags <= r_flags | i_done;
            end
            if (i_count && !o_timeout) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // A done arriving this cycle counts immediately, saving a WAIT cycle
    assign o_all_done = &(r_flags | i_done);
    assign o_timeout  = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/karatsuba_18b_uc.sv
// Control FSM for the 18x18 Karatsuba datapath: launches the three 10b
// sub-multipliers, waits for them, then sequences the z1 and product merges.
module karatsuba_18b_uc
    import karatsuba_18b_uc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    karatsuba_18b_uc_if.slave  bus,
    output state_t             o_dbg_state
);

    state_t r_state;
    state_t w_next;
    logic   r_err;
    logic   w_err_next;
    ctrl_t  w_ctrl;
    logic   w_clear;
    logic   w_capture;
    logic   w_count;
    logic   w_all_done;
    logic   w_timeout;

    assign w_clear   = (r_state == ST_LOAD_A);
    assign w_capture = (r_state == ST_LOAD_B) || (r_state == ST_WAIT);
    assign w_count   = (r_state == ST_WAIT);

    karatsuba_18b_uc_done_tracker #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_capture  (w_capture),
        .i_count    (w_count),
        .i_done     ({bus.done3, bus.done2, bus.done1}),
        .o_all_done (w_all_done),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err_next = 1'b0;
        w_ctrl     = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                // reg2 captures a_hi+a_lo, which becomes the kara3 A operand
                w_ctrl.sel_alu_a = SEL_A_A_HI;
                w_ctrl.sel_alu_b = SEL_B_A_LO;
                w_ctrl.load_reg2 = 1'b1;
                w_ctrl.start1    = 1'b1;
                w_ctrl.start2    = 1'b1;
                w_ctrl.busy      = 1'b1;
                w_next           = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                w_ctrl.sel_alu_a = SEL_A_B_HI;
                w_ctrl.sel_alu_b = SEL_B_B_LO;
                w_ctrl.start3    = 1'b1;
                w_ctrl.busy      = 1'b1;
                w_next           = ST_WAIT;
            end
            ST_WAIT: begin
                // Keep b_hi+b_lo on the adder so kara3's operand stays stable
                w_ctrl.sel_alu_a = SEL_A_B_HI;
                w_ctrl.sel_alu_b = SEL_B_B_LO;
                w_ctrl.busy      = 1'b1;
                if (w_all_done) begin
                    w_next = ST_Z02;
                end else if (w_timeout) begin
                    w_next     = ST_IDLE;
                    w_err_next = 1'b1;
                end
            end
            ST_Z02: begin
                w_ctrl.sel_alu_a  = SEL_A_KARA;
                w_ctrl.sel_alu_a1 = SEL_A1_KARA1;
                w_ctrl.shamt      = SHAMT_NONE;
                w_ctrl.sel_alu_b  = SEL_B_KARA2;
                w_ctrl.load_reg3  = 1'b1;
                w_ctrl.busy       = 1'b1;
                w_next            = ST_Z1;
            end
            ST_Z1: begin
                w_ctrl.sel_alu_a  = SEL_A_KARA;
                w_ctrl.sel_alu_a1 = SEL_A1_KARA3;
                w_ctrl.shamt      = SHAMT_NONE;
                w_ctrl.sel_alu_b  = SEL_B_REG3;
                w_ctrl.sub        = 1'b1;
                w_ctrl.load_reg3  = 1'b1;
                w_ctrl.busy       = 1'b1;
                w_next            = ST_HILO;
            end
            ST_HILO: begin
                w_ctrl.sel_alu_a  = SEL_A_KARA;
                w_ctrl.sel_alu_a1 = SEL_A1_KARA1;
                w_ctrl.shamt      = SHAMT_HI;
                w_ctrl.sel_alu_b  = SEL_B_KARA2;
                w_ctrl.load_reg1  = 1'b1;
                w_ctrl.load_reg2  = 1'b1;
                w_ctrl.busy       = 1'b1;
                w_next            = ST_MERGE;
            end
            ST_MERGE: begin
                w_ctrl.sel_alu_a = SEL_A_REGS;
                w_ctrl.sel_alu_b = SEL_B_REG3;
                w_ctrl.shamt     = SHAMT_HI;
                w_ctrl.load_reg1 = 1'b1;
                w_ctrl.load_reg2 = 1'b1;
                w_ctrl.busy      = 1'b1;
                w_next           = ST_DONE;
            end
            ST_DONE: begin
                w_ctrl.done = 1'b1;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign bus.start1     = w_ctrl.start1;
    assign bus.start2     = w_ctrl.start2;
    assign bus.start3     = w_ctrl.start3;
    assign bus.sel_alu_a  = w_ctrl.sel_alu_a;
    assign bus.sel_alu_b  = w_ctrl.sel_alu_b;
    assign bus.sel_alu_a1 = w_ctrl.sel_alu_a1;
    assign bus.shamt      = w_ctrl.shamt;
    assign bus.sub        = w_ctrl.sub;
    assign bus.load_reg1  = w_ctrl.load_reg1;
    assign bus.load_reg2  = w_ctrl.load_reg2;
    assign bus.load_reg3  = w_ctrl.load_reg3;
    assign bus.busy       = w_ctrl.busy;
    assign bus.done       = w_ctrl.done;
    assign bus.err        = r_err;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_karatsuba_18b_uc.sv
// Bench for the Karatsuba control unit with a behavioural datapath and
// sub-multipliers of programmable latency; results go through an expected queue.
module tb_karatsuba_18b_uc;
    import karatsuba_18b_uc_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp_q[$];
    int          cyc_q[$];

    karatsuba_18b_uc_if bus();

    karatsuba_18b_uc #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .reset       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath
    logic [17:0] a_in = '0;
    logic [17:0] b_in = '0;
    logic [17:0] reg1, reg2;
    logic [19:0] reg3;
    logic [35:0] alu_a, alu_b, adder;
    logic [19:0] kara_sel;
    logic [19:0] kp[3];

    always_comb begin
        kara_sel = bus.sel_alu_a1 ? kp[0] : kp[2];
        alu_a = '0;
        alu_b = '0;
        case (bus.sel_alu_a)
            2'd0:    alu_a = 36'(a_in[17:9]);
            2'd1:    alu_a = 36'(b_in[17:9]);
            2'd2:    alu_a = bus.shamt ? (36'(kara_sel) << 18) : 36'(kara_sel);
            default: alu_a = {reg1, reg2};
        endcase
        case (bus.sel_alu_b)
            2'd0:    alu_b = 36'(a_in[8:0]);
            2'd1:    alu_b = 36'(b_in[8:0]);
            2'd2:    alu_b = bus.shamt ? (36'(reg3) << 9) : 36'(reg3);
            default: alu_b = 36'(kp[1]);
        endcase
        adder = bus.sub ? (alu_a - alu_b) : (alu_a + alu_b);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            reg1 <= '0;
            reg2 <= '0;
            reg3 <= '0;
        end else begin
            if (bus.load_reg1) reg1 <= adder[35:18];
            if (bus.load_reg2) reg2 <= adder[17:0];
            if (bus.load_reg3) reg3 <= adder[19:0];
        end
    end

    // Sub-multipliers: done pulses lat cycles after the start cycle; lat=0 never finishes
    int   cnt[3]  = '{0, 0, 0};
    int   lat[3]  = '{1, 1, 1};
    logic held[3] = '{1'b0, 1'b0, 1'b0};
    logic inj[3]  = '{1'b0, 1'b0, 1'b0};
    bit   level_mode = 1'b0;
    logic [2:0] w_st;
    assign w_st = {bus.start3, bus.start2, bus.start1};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_st[i]) cnt[i] <= lat[i];
            else if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
            if (w_st[0]) held[i] <= 1'b0;
            else if (cnt[i] == 1 && !w_st[i]) held[i] <= 1'b1;
        end
        if (w_st[0]) kp[0] <= 20'(a_in[17:9]) * 20'(b_in[17:9]);
        if (w_st[1]) kp[1] <= 20'(a_in[8:0]) * 20'(b_in[8:0]);
        if (w_st[2]) kp[2] <= 20'(reg2[9:0]) * 20'(adder[9:0]);
    end

    assign bus.done1 = (cnt[0] == 1) | (level_mode & held[0]) | inj[0];
    assign bus.done2 = (cnt[1] == 1) | (level_mode & held[1]) | inj[1];
    assign bus.done3 = (cnt[2] == 1) | (level_mode & held[2]) | inj[2];

    function automatic logic [14:0] mk(logic s1, logic s2, logic s3, logic [1:0] sa,
                                       logic [1:0] sb, logic a1, logic sh, logic su,
                                       logic l1, logic l2, logic l3, logic bz, logic dn);
        return {s1, s2, s3, sa, sb, a1, sh, su, l1, l2, l3, bz, dn};
    endfunction

    function automatic logic [14:0] exp_ctrl(state_t s);
        case (s)
            ST_IDLE:   return mk(L, L, L, 2'd0, 2'd0, L, L, L, L, L, L, L, L);
            ST_LOAD_A: return mk(H, H, L, 2'd0, 2'd0, L, L, L, L, H, L, H, L);
            ST_LOAD_B: return mk(L, L, H, 2'd1, 2'd1, L, L, L, L, L, L, H, L);
            ST_WAIT:   return mk(L, L, L, 2'd1, 2'd1, L, L, L, L, L, L, H, L);
            ST_Z02:    return mk(L, L, L, 2'd2, 2'd3, H, L, L, L, L, H, H, L);
            ST_Z1:     return mk(L, L, L, 2'd2, 2'd2, L, L, H, L, L, H, H, L);
            ST_HILO:   return mk(L, L, L, 2'd2, 2'd3, H, H, L, H, H, L, H, L);
            ST_MERGE:  return mk(L, L, L, 2'd3, 2'd2, L, H, L, H, H, L, H, L);
            ST_DONE:   return mk(L, L, L, 2'd0, 2'd0, L, L, L, L, L, L, L, H);
            default:   return 15'h7FFF;
        endcase
    endfunction

    function automatic logic [14:0] act_ctrl();
        return {bus.start1, bus.start2, bus.start3, bus.sel_alu_a, bus.sel_alu_b,
                bus.sel_alu_a1, bus.shamt, bus.sub, bus.load_reg1, bus.load_reg2,
                bus.load_reg3, bus.busy, bus.done};
    endfunction

    task automatic monitor_step();
        logic [36:0] e;
        int          ec;
        logic        ok;
        n_checks++;
        if (act_ctrl() !== exp_ctrl(dbg_state)) begin
            n_fail++;
            $display("FAIL ctrl_vec state=%0d: got %h expected %h", dbg_state, act_ctrl(), exp_ctrl(dbg_state));
        end
        if (bus.done || bus.err) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: got done=%b err=%b expected none", bus.done, bus.err);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                if (e[36]) ok = bus.err && !bus.done;
                else       ok = bus.done && !bus.err && ({reg1, reg2} == e[35:0]);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL result: got err=%b done=%b s=%h expected err=%b s=%h",
                             bus.err, bus.done, {reg1, reg2}, e[36], e[35:0]);
                end
                n_checks++;
                if (cyc != ec) begin
                    n_fail++;
                    $display("FAIL latency: got cycle %0d expected %0d", cyc, ec);
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({act_ctrl(), bus.err} !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s outputs: got %h expected 0000", name, {act_ctrl(), bus.err});
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", name, dbg_state, ST_IDLE);
        end
    endtask

    task automatic launch(input logic [17:0] a, input logic [17:0] b, input int l1, input int l2,
                          input int l3, input logic [35:0] exp_p, input int exp_cyc, input logic exp_err);
        a_in = a;
        b_in = b;
        lat[0] = l1;
        lat[1] = l2;
        lat[2] = l3;
        @(negedge clk);
        bus.start = 1'b1;
        exp_q.push_back({exp_err, exp_p});
        cyc_q.push_back(cyc + exp_cyc);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_op(input logic [17:0] a, input logic [17:0] b, input int l1, input int l2,
                         input int l3, input logic [35:0] exp_p, input int exp_cyc,
                         input logic exp_err, input bit pulse);
        bit got = 1'b0;
        launch(a, b, l1, l2, l3, exp_p, exp_cyc, exp_err);
        for (int k = 0; k < 200; k++) begin
            if (bus.done || bus.err) begin
                got = 1'b1;
                break;
            end
            bus.start = pulse && (k == 3 || k == 7 || k == 12);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_resp: got no done/err expected response within 200 cycles");
        end
    endtask

    task automatic abort_in_z1();
        bit got = 1'b0;
        launch(18'd11, 18'd13, 2, 2, 2, 36'd143, 9, 1'b0);
        for (int k = 0; k < 50; k++) begin
            if (dbg_state == ST_Z1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL reach_z1: got state %0d expected %0d", dbg_state, ST_Z1);
        end
        #2 rst = 1'b1;
        #1 check_idle("reset_mid_op");
        void'(exp_q.pop_back());
        void'(cyc_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        inj[2] = 1'b1;
        @(negedge clk);
        inj[2] = 1'b0;
        @(negedge clk);
        check_idle("stale_done3");
    endtask

    initial begin
        bus.start = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (!rst) monitor_step();
            end
        join_none
        repeat (2) @(negedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        do_op(18'h3FFFF, 18'h3FFFF, 3, 3, 3, 36'hFFFF80001, 10, 1'b0, 1'b0);
        do_op(18'd300, 18'd700, 1, 2, 9, 36'd210000, 16, 1'b0, 1'b1);
        do_op(18'h00000, 18'h2ABCD, 1, 1, 1, 36'h0, 8, 1'b0, 1'b0);
        do_op(18'd512, 18'd513, 2, 1, 1, 36'h000040200, 8, 1'b0, 1'b0);
        level_mode = 1'b1;
        do_op(18'd1000, 18'd1000, 1, 4, 2, 36'h0000F4240, 10, 1'b0, 1'b0);
        level_mode = 1'b0;
        do_op(18'h20000, 18'd2, 3, 3, 3, 36'h000040000, 10, 1'b0, 1'b0);
        do_op(18'd5, 18'd6, 2, 2, 0, 36'h0, 67, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_idle("after_timeout");
        abort_in_z1();
        do_op(18'd7, 18'd9, 2, 2, 6, 36'd63, 13, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
